// File: rtl/array_access_arbiter.sv
// Two-requester arbiter in front of a 4-entry register array, with round-robin
// fairness and a per-requester lock that keeps the grant across transactions.
module array_access_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,

   input  logic                     a_req_valid,
   output logic                     a_req_ready,
   input  logic                     a_req_we,
   input  logic [1:0]               a_req_idx,
   input  logic [WIDTH-1:0]         a_req_wdata,
   input  logic                     a_req_lock,
   output logic                     a_rsp_valid,
   output logic [WIDTH-1:0]         a_rsp_rdata,

   input  logic                     b_req_valid,
   output logic                     b_req_ready,
   input  logic                     b_req_we,
   input  logic [1:0]               b_req_idx,
   input  logic [WIDTH-1:0]         b_req_wdata,
   input  logic                     b_req_lock,
   output logic                     b_rsp_valid,
   output logic [WIDTH-1:0]         b_rsp_rdata,

   output logic [WIDTH*DEPTH-1:0]   mem_flat
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } arbState_t;

   arbState_t        r_state;
   arbState_t        w_stateNext;
   logic             r_rr;
   logic             w_rrNext;
   logic             w_grantA;
   logic             w_grantB;
   logic             w_xfer;
   logic             w_we;
   logic [1:0]       w_idx;
   logic [WIDTH-1:0] w_wdata;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             r_aRspValid;
   logic             r_bRspValid;
   logic [WIDTH-1:0] r_aRspRdata;
   logic [WIDTH-1:0] r_bRspRdata;

   // Grant decision and next-state; rr always moves to the side that was not just served.
   always_comb begin
      w_stateNext = r_state;
      w_rrNext    = r_rr;
      w_grantA    = 1'b0;
      w_grantB    = 1'b0;
      if (rst_n) begin
         case (r_state)
            IDLE: begin
               if (a_req_valid && b_req_valid) begin
                  w_grantA = ~r_rr;
                  w_grantB = r_rr;
               end else begin
                  w_grantA = a_req_valid;
                  w_grantB = b_req_valid;
               end
            end
            LOCK_A:  w_grantA = a_req_valid;
            LOCK_B:  w_grantB = b_req_valid;
            default: w_stateNext = IDLE;
         endcase
         if (w_grantA) begin
            w_stateNext = a_req_lock ? LOCK_A : IDLE;
            w_rrNext    = 1'b1;
         end else if (w_grantB) begin
            w_stateNext = b_req_lock ? LOCK_B : IDLE;
            w_rrNext    = 1'b0;
         end
      end
   end

   assign a_req_ready = w_grantA;
   assign b_req_ready = w_grantB;
   assign w_xfer      = w_grantA | w_grantB;
   assign w_we        = w_grantB ? b_req_we    : a_req_we;
   assign w_idx       = w_grantB ? b_req_idx   : a_req_idx;
   assign w_wdata     = w_grantB ? b_req_wdata : a_req_wdata;

   // Array, arbiter state and responses; reset drops any lock and pending response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rr        <= 1'b0;
         r_aRspValid <= 1'b0;
         r_bRspValid <= 1'b0;
         r_aRspRdata <= '0;
         r_bRspRdata <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= WIDTH'(13 - i);
         end
      end else begin
         r_state     <= w_stateNext;
         r_rr        <= w_rrNext;
         r_aRspValid <= w_grantA;
         r_bRspValid <= w_grantB;
         if (w_grantA) begin
            r_aRspRdata <= r_mem[w_idx];
         end
         if (w_grantB) begin
            r_bRspRdata <= r_mem[w_idx];
         end
         if (w_xfer && w_we) begin
            r_mem[w_idx] <= w_wdata;
         end
      end
   end

   assign a_rsp_valid = r_aRspValid;
   assign b_rsp_valid = r_bRspValid;
   assign a_rsp_rdata = r_aRspRdata;
   assign b_rsp_rdata = r_bRspRdata;

   for (genvar g = 0; g < DEPTH; g++) begin : genFlat
      assign mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
   end

   // Structural guarantees of the grant logic.
   assert property (@(posedge clk) !(a_req_ready && b_req_ready));
   assert property (@(posedge clk) (!a_req_ready || a_req_valid) && (!b_req_ready || b_req_valid));

endmodule

// File: tb/tb_array_access_arbiter.sv
// Randomized and directed bench for array_access_arbiter: a reference model
// predicts grants and array contents, and a scoreboard checks the responses.
module tb_array_access_arbiter;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          a_req_valid = 1'b0, a_req_we = 1'b0, a_req_lock = 1'b0;
   logic [1:0]    a_req_idx = '0;
   logic [31:0]   a_req_wdata = '0;
   logic          b_req_valid = 1'b0, b_req_we = 1'b0, b_req_lock = 1'b0;
   logic [1:0]    b_req_idx = '0;
   logic [31:0]   b_req_wdata = '0;
   logic          a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
   logic [31:0]   a_rsp_rdata, b_rsp_rdata;
   logic [127:0]  mem_flat;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: array contents, lock owner (-1 none, 0 A, 1 B) and preferred side.
   logic [31:0] mdlMem [4];
   int          mdlOwner = -1;
   int          mdlRr = 0;
   bit          mdlValid = 1'b0;
   logic [31:0] qA [$];
   logic [31:0] qB [$];
   logic [31:0] lastA = '0;
   logic [31:0] lastB = '0;

   array_access_arbiter #(.WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_idx(a_req_idx), .a_req_wdata(a_req_wdata), .a_req_lock(a_req_lock),
      .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_idx(b_req_idx), .b_req_wdata(b_req_wdata), .b_req_lock(b_req_lock),
      .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
      .mem_flat(mem_flat)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [127:0] actual, logic [127:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endfunction

   // Compares the ready outputs and array view with the model, then advances the model.
   task automatic checkOutput();
      int grant;
      int idx;
      grant = -1;
      if (rst_n) begin
         if (mdlOwner == 0) grant = a_req_valid ? 0 : -1;
         else if (mdlOwner == 1) grant = b_req_valid ? 1 : -1;
         else if (a_req_valid && b_req_valid) grant = mdlRr;
         else if (a_req_valid) grant = 0;
         else if (b_req_valid) grant = 1;
      end
      check("a_req_ready", 128'(a_req_ready), 128'(grant == 0));
      check("b_req_ready", 128'(b_req_ready), 128'(grant == 1));
      if (mdlValid) begin
         check("mem_flat", mem_flat, {mdlMem[3], mdlMem[2], mdlMem[1], mdlMem[0]});
      end
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) mdlMem[i] = 32'(13 - i);
         mdlOwner = -1;
         mdlRr    = 0;
         mdlValid = 1'b1;
      end else if (grant >= 0) begin
         idx = (grant == 0) ? int'(a_req_idx) : int'(b_req_idx);
         if (grant == 0) qA.push_back(mdlMem[idx]);
         else            qB.push_back(mdlMem[idx]);
         if (grant == 0 && a_req_we) mdlMem[idx] = a_req_wdata;
         if (grant == 1 && b_req_we) mdlMem[idx] = b_req_wdata;
         if ((grant == 0) ? a_req_lock : b_req_lock) mdlOwner = grant;
         else                                        mdlOwner = -1;
         mdlRr = 1 - grant;
      end
   endtask

   // Drives one cycle of inputs just after the rising edge and checks them.
   task automatic applyStimulus(input logic rst, input logic av, input logic awe,
                                input logic [1:0] aidx, input logic [31:0] awd, input logic alk,
                                input logic bv, input logic bwe, input logic [1:0] bidx,
                                input logic [31:0] bwd, input logic blk);
      @(posedge clk);
      #2;
      rst_n = rst;
      a_req_valid = av; a_req_we = awe; a_req_idx = aidx; a_req_wdata = awd; a_req_lock = alk;
      b_req_valid = bv; b_req_we = bwe; b_req_idx = bidx; b_req_wdata = bwd; b_req_lock = blk;
      #1;
      checkOutput();
   endtask

   // Scoreboard monitor: pops one expected value per response pulse.
   initial begin
      bit wasReset;
      forever begin
         @(posedge clk);
         wasReset = !rst_n;
         #1;
         if (wasReset) begin
            qA.delete();
            qB.delete();
            lastA = '0;
            lastB = '0;
            check("a_rsp_valid_rst", 128'(a_rsp_valid), 128'(0));
            check("b_rsp_valid_rst", 128'(b_rsp_valid), 128'(0));
            check("a_rsp_rdata_rst", 128'(a_rsp_rdata), 128'(0));
            check("b_rsp_rdata_rst", 128'(b_rsp_rdata), 128'(0));
         end else begin
            check("a_rsp_valid", 128'(a_rsp_valid), 128'(qA.size() != 0));
            check("b_rsp_valid", 128'(b_rsp_valid), 128'(qB.size() != 0));
            if (a_rsp_valid && qA.size() != 0) lastA = qA.pop_front();
            if (b_rsp_valid && qB.size() != 0) lastB = qB.pop_front();
            check("a_rsp_rdata", 128'(a_rsp_rdata), 128'(lastA));
            check("b_rsp_rdata", 128'(b_rsp_rdata), 128'(lastB));
         end
      end
   end

   initial begin
      // Reset, then A reads 0..3 back-to-back.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 2'(i), 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Contested reads alternate between A and B.
      for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 2'(i), 0, 0, 1, 0, 2'(i + 1), 0, 0);

      // Write then read from the other side.
      applyStimulus(1, 1, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);

      // A holds a lock, goes idle mid-lock, then releases; B waits throughout.
      applyStimulus(1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0);
      applyStimulus(1, 1, 1, 1, 32'h1111_2222, 1, 1, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus(1, 1, 0, 3, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

      // B locks, reset arrives with a write presented, then a contested grant.
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'hCAFE_0000, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 3, 32'hCAFE_0001, 1);
      applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      applyStimulus(1, 1, 0, 2, 0, 0, 1, 0, 3, 0, 0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0),
                       ($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom), $urandom,
                       ($urandom_range(0, 9) < 3),
                       ($urandom_range(0, 9) < 7), 1'($urandom), 2'($urandom), $urandom,
                       ($urandom_range(0, 9) < 3));
      end

      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      check("qA_drained", 128'(qA.size()), 128'(0));
      check("qB_drained", 128'(qB.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
      $finish;
   end

endmodule
